// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch command scheduler: command codes, control
// bit map, accepted UART characters, scheduler states and small decode helpers.
package stopwatch_pkg;

   localparam logic [2:0] CMD_NONE  = 3'd0;
   localparam logic [2:0] CMD_HOUR  = 3'd1;
   localparam logic [2:0] CMD_MIN   = 3'd2;
   localparam logic [2:0] CMD_SEC   = 3'd3;
   localparam logic [2:0] CMD_RUN   = 3'd4;
   localparam logic [2:0] CMD_CLEAR = 3'd5;

   localparam int CTL_HOUR  = 0;
   localparam int CTL_MIN   = 1;
   localparam int CTL_SEC   = 2;
   localparam int CTL_RUN   = 3;
   localparam int CTL_CLEAR = 4;
   localparam int CTL_W     = 5;

   localparam logic [7:0] ASC_H_UC = 8'h48;
   localparam logic [7:0] ASC_H_LC = 8'h68;
   localparam logic [7:0] ASC_M_UC = 8'h4D;
   localparam logic [7:0] ASC_M_LC = 8'h6D;
   localparam logic [7:0] ASC_S_UC = 8'h53;
   localparam logic [7:0] ASC_S_LC = 8'h73;
   localparam logic [7:0] ASC_R_UC = 8'h52;
   localparam logic [7:0] ASC_R_LC = 8'h72;
   localparam logic [7:0] ASC_C_UC = 8'h43;
   localparam logic [7:0] ASC_C_LC = 8'h63;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } sched_state_e;

   // Lowest set button bit wins; the rest are discarded without complaint.
   function automatic logic [2:0] btn_decode(input logic [CTL_W-1:0] b);
      logic [2:0] code;
      code = CMD_NONE;
      if (b[CTL_HOUR])       code = CMD_HOUR;
      else if (b[CTL_MIN])   code = CMD_MIN;
      else if (b[CTL_SEC])   code = CMD_SEC;
      else if (b[CTL_RUN])   code = CMD_RUN;
      else if (b[CTL_CLEAR]) code = CMD_CLEAR;
      return code;
   endfunction

   function automatic logic [2:0] uart_decode(input logic [7:0] ch);
      logic [2:0] code;
      case (ch)
         ASC_H_UC, ASC_H_LC: code = CMD_HOUR;
         ASC_M_UC, ASC_M_LC: code = CMD_MIN;
         ASC_S_UC, ASC_S_LC: code = CMD_SEC;
         ASC_R_UC, ASC_R_LC: code = CMD_RUN;
         ASC_C_UC, ASC_C_LC: code = CMD_CLEAR;
         default:            code = CMD_NONE;
      endcase
      return code;
   endfunction

   function automatic logic [CTL_W-1:0] cmd_onehot(input logic [2:0] code);
      logic [CTL_W-1:0] oh;
      oh = '0;
      case (code)
         CMD_HOUR:  oh[CTL_HOUR]  = 1'b1;
         CMD_MIN:   oh[CTL_MIN]   = 1'b1;
         CMD_SEC:   oh[CTL_SEC]   = 1'b1;
         CMD_RUN:   oh[CTL_RUN]   = 1'b1;
         CMD_CLEAR: oh[CTL_CLEAR] = 1'b1;
         default:   oh = '0;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO for command codes. Pointers carry one extra wrap bit so
// that occupancy is simply write pointer minus read pointer.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   // A push into a full queue is refused even if a pop frees a slot this cycle.
   always_comb begin
      count    = wr_ptr_q - rd_ptr_q;
      full     = (count == (AW+1)'(DEPTH));
      empty    = (count == '0);
      push_ok  = push && !full;
      pop_ok   = pop && !empty;
      wr_ptr_d = push_ok ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
      rd_ptr_d = pop_ok  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
      dout     = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/stopwatch_cmd_scheduler.sv
// Merges button and UART stopwatch commands into a FIFO and issues them as
// registered one-hot control pulses separated by a fixed idle gap.
module stopwatch_cmd_scheduler
   import stopwatch_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int GAP_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [4:0]                    btn_pulse,
   input  logic [7:0]                    rx_data,
   input  logic                          rx_valid,
   input  logic                          ovf_clr,
   output logic [4:0]                    control,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   pending,
   output logic                          overflow
);

   localparam int GW = $clog2(GAP_CYCLES + 1);

   sched_state_e state_q, state_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [4:0]    control_q, control_d;
   logic          overflow_q, overflow_d;
   logic          skid_vld_q, skid_vld_d;
   logic [2:0]    skid_code_q, skid_code_d;

   logic [2:0]    btn_code;
   logic [2:0]    uart_code;
   logic          wr_req;
   logic [2:0]    wr_code;
   logic          drop;
   logic          ovf_set;
   logic          push;
   logic          pop;
   logic [2:0]    fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;

   // Write arbitration: a displaced UART command in the skid always drains first.
   always_comb begin
      btn_code    = btn_decode(btn_pulse);
      uart_code   = rx_valid ? uart_decode(rx_data) : CMD_NONE;
      skid_vld_d  = 1'b0;
      skid_code_d = skid_code_q;
      wr_req      = 1'b0;
      wr_code     = CMD_NONE;
      drop        = 1'b0;
      if (skid_vld_q) begin
         wr_req  = 1'b1;
         wr_code = skid_code_q;
         drop    = (btn_code != CMD_NONE) || (uart_code != CMD_NONE);
      end else if (btn_code != CMD_NONE) begin
         wr_req  = 1'b1;
         wr_code = btn_code;
         if (uart_code != CMD_NONE) begin
            skid_vld_d  = 1'b1;
            skid_code_d = uart_code;
         end
      end else if (uart_code != CMD_NONE) begin
         wr_req  = 1'b1;
         wr_code = uart_code;
      end
      push       = wr_req && !fifo_full;
      ovf_set    = drop || (wr_req && fifo_full);
      overflow_d = overflow_q;
      if (ovf_set)      overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;
   end

   // Issue FSM: control is loaded on the IDLE->ISSUE edge so it is purely registered.
   always_comb begin
      state_d   = state_q;
      gap_cnt_d = gap_cnt_q;
      control_d = '0;
      pop       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               control_d = cmd_onehot(fifo_dout);
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            gap_cnt_d = GW'(GAP_CYCLES);
            state_d   = ST_GAP;
         end
         ST_GAP: begin
            gap_cnt_d = gap_cnt_q - GW'(1);
            if (gap_cnt_q == GW'(1)) state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         gap_cnt_q  <= '0;
         control_q  <= '0;
         overflow_q <= 1'b0;
         skid_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_cnt_q  <= gap_cnt_d;
         control_q  <= control_d;
         overflow_q <= overflow_d;
         skid_vld_q <= skid_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      skid_code_q <= skid_code_d;
   end

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (3)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (wr_code),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign control  = control_q;
   assign overflow = overflow_q;
   assign pending  = fifo_count;
   assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_stopwatch_cmd_scheduler.sv
// Bench for stopwatch_cmd_scheduler: directed vector table, hand sequences for
// arbitration/overflow/reset corners, and random traffic against a timing model.
module tb_stopwatch_cmd_scheduler;

   localparam int DEPTH = 4;
   localparam int GAP   = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] btn_pulse = '0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic       ovf_clr = 1'b0;
   logic [4:0] control;
   logic       busy;
   logic [2:0] pending;
   logic       overflow;

   always #5 clk = ~clk;

   stopwatch_cmd_scheduler #(
      .FIFO_DEPTH (DEPTH),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_pulse (btn_pulse),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .ovf_clr   (ovf_clr),
      .control   (control),
      .busy      (busy),
      .pending   (pending),
      .overflow  (overflow)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: queue of codes, skid slot, sticky flag and the earliest
   // cycle at which the next command may be taken from the queue.
   int         mq[$];
   int         m_skid = 0;
   bit         m_ovf = 1'b0;
   int         m_cyc = 0;
   int         m_ready = 0;
   logic [4:0] m_ctl = '0;

   logic [4:0] pulses[$];
   int         max_pend = 0;

   typedef struct {
      logic       rst;
      logic [4:0] btn;
      logic       rxv;
      logic [7:0] rxd;
      logic       clr;
      logic [4:0] e_ctl;
      logic [2:0] e_pend;
      logic       e_busy;
      logic       e_ovf;
   } vec_t;
   vec_t tbl[$];

   function automatic int ref_btn(input logic [4:0] b);
      for (int i = 0; i < 5; i++) if (b[i]) return i + 1;
      return 0;
   endfunction

   function automatic int ref_uart(input logic [7:0] c);
      logic [7:0] u;
      u = c;
      if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
      case (u)
         "H": return 1;
         "M": return 2;
         "S": return 3;
         "R": return 4;
         "C": return 5;
         default: return 0;
      endcase
   endfunction

   task automatic model_step(input logic r, input logic [4:0] b, input logic v,
                             input logic [7:0] d, input logic clr);
      int  c;
      int  bc;
      int  uc;
      int  want;
      int  code;
      bit  full;
      bit  set;
      bit  pop;
      c = m_cyc;
      if (r) begin
         mq.delete();
         m_skid  = 0;
         m_ovf   = 1'b0;
         m_ctl   = '0;
         m_ready = c + 1;
      end else begin
         bc   = ref_btn(b);
         uc   = v ? ref_uart(d) : 0;
         full = (mq.size() == DEPTH);
         pop  = (mq.size() > 0) && (c >= m_ready);
         set  = 1'b0;
         want = 0;
         if (m_skid != 0) begin
            want   = m_skid;
            m_skid = 0;
            if (bc != 0 || uc != 0) set = 1'b1;
         end else if (bc != 0) begin
            want   = bc;
            m_skid = uc;
         end else begin
            want = uc;
         end
         m_ctl = '0;
         if (pop) begin
            code = mq.pop_front();
            m_ctl[code-1] = 1'b1;
            m_ready = c + GAP + 2;
         end
         if (want != 0) begin
            if (full) set = 1'b1;
            else mq.push_back(want);
         end
         if (set) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
      end
      m_cyc = c + 1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic r, input logic [4:0] b, input logic v,
                      input logic [7:0] d, input logic clr);
      reset     = r;
      btn_pulse = b;
      rx_valid  = v;
      rx_data   = d;
      ovf_clr   = clr;
      @(posedge clk);
      model_step(r, b, v, d, clr);
      #1;
      chk("control", 8'(control), 8'(m_ctl));
      chk("pending", 8'(pending), 8'(mq.size()));
      chk("busy", 8'(busy), 8'((mq.size() > 0) || (m_cyc < m_ready)));
      chk("overflow", 8'(overflow), 8'(m_ovf));
      if (control != '0) pulses.push_back(control);
      if (int'(pending) > max_pend) max_pend = int'(pending);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 5'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic add(input logic r, input logic [4:0] b, input logic v, input logic [7:0] d,
                      input logic clr, input logic [4:0] ec, input logic [2:0] ep,
                      input logic eb, input logic eo);
      vec_t t;
      t.rst = r; t.btn = b; t.rxv = v; t.rxd = d; t.clr = clr;
      t.e_ctl = ec; t.e_pend = ep; t.e_busy = eb; t.e_ovf = eo;
      tbl.push_back(t);
   endtask

   task automatic pad_pulses(input int n);
      while (pulses.size() < n) pulses.push_back('x);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Single button command, then UART RUN/CLEAR pair and an ignored byte.
      add(1, 5'b0, 0, 8'h00, 0, 5'b00000, 3'd0, 0, 0);
      add(1, 5'b0, 0, 8'h00, 0, 5'b00000, 3'd0, 0, 0);
      for (int i = 2; i < 10; i++) add(0, 5'b0, 0, 8'h00, 0, 5'b00000, 3'd0, 0, 0);
      add(0, 5'b00100, 0, 8'h00, 0, 5'b00000, 3'd1, 1, 0);
      add(0, 5'b0, 0, 8'h00, 0, 5'b00100, 3'd0, 1, 0);
      for (int i = 12; i < 16; i++) add(0, 5'b0, 0, 8'h00, 0, 5'b00000, 3'd0, 1, 0);
      add(0, 5'b0, 0, 8'h00, 0, 5'b00000, 3'd0, 0, 0);
      add(0, 5'b0, 1, 8'h72, 0, 5'b00000, 3'd1, 1, 0);
      add(0, 5'b0, 1, 8'h43, 0, 5'b01000, 3'd1, 1, 0);
      for (int i = 19; i < 24; i++) add(0, 5'b0, 0, 8'h00, 0, 5'b00000, 3'd1, 1, 0);
      add(0, 5'b0, 0, 8'h00, 0, 5'b10000, 3'd0, 1, 0);
      for (int i = 25; i < 29; i++) add(0, 5'b0, 0, 8'h00, 0, 5'b00000, 3'd0, 1, 0);
      add(0, 5'b0, 0, 8'h00, 0, 5'b00000, 3'd0, 0, 0);
      add(0, 5'b0, 1, 8'h5A, 0, 5'b00000, 3'd0, 0, 0);
      add(0, 5'b0, 0, 8'h00, 0, 5'b00000, 3'd0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].rst, tbl[i].btn, tbl[i].rxv, tbl[i].rxd, tbl[i].clr);
         chk($sformatf("tbl%0d_ctl", i), 8'(control), 8'(tbl[i].e_ctl));
         chk($sformatf("tbl%0d_pend", i), 8'(pending), 8'(tbl[i].e_pend));
         chk($sformatf("tbl%0d_busy", i), 8'(busy), 8'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_ovf", i), 8'(overflow), 8'(tbl[i].e_ovf));
      end

      // Simultaneous button and UART: both issued, button first.
      cyc(1'b1, 5'b0, 1'b0, 8'h00, 1'b0);
      pulses.delete();
      cyc(1'b0, 5'b00001, 1'b1, 8'h6D, 1'b0);
      idle(15);
      chk("both_count", 8'(pulses.size()), 8'd2);
      pad_pulses(2);
      chk("both_first", 8'(pulses[0]), 8'b00001);
      chk("both_second", 8'(pulses[1]), 8'b00010);
      chk("both_ovf", 8'(overflow), 8'd0);
      pulses.delete();
      cyc(1'b0, 5'b01010, 1'b0, 8'h00, 1'b0);
      idle(8);
      chk("multibtn_count", 8'(pulses.size()), 8'd1);
      pad_pulses(1);
      chk("multibtn_code", 8'(pulses[0]), 8'b00010);

      // Skid occupied when a new button and UART pair arrive.
      cyc(1'b1, 5'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 5'b00001, 1'b1, 8'h4D, 1'b0);
      chk("skid_load_ovf", 8'(overflow), 8'd0);
      cyc(1'b0, 5'b00100, 1'b1, 8'h53, 1'b0);
      chk("skid_drop_ovf", 8'(overflow), 8'd1);
      cyc(1'b0, 5'b0, 1'b0, 8'h00, 1'b1);
      chk("ovf_clear", 8'(overflow), 8'd0);
      cyc(1'b0, 5'b00001, 1'b1, 8'h4D, 1'b0);
      cyc(1'b0, 5'b00010, 1'b0, 8'h00, 1'b1);
      chk("ovf_set_beats_clr", 8'(overflow), 8'd1);
      idle(30);

      // Burst of six pushes while the first command is being issued.
      cyc(1'b1, 5'b0, 1'b0, 8'h00, 1'b0);
      pulses.delete();
      max_pend = 0;
      cyc(1'b0, 5'b00100, 1'b0, 8'h00, 1'b0);
      idle(1);
      cyc(1'b0, 5'b00001, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 5'b00010, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 5'b00100, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 5'b01000, 1'b0, 8'h00, 1'b0);
      chk("burst_full", 8'(pending), 8'd4);
      cyc(1'b0, 5'b10000, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 5'b00001, 1'b0, 8'h00, 1'b0);
      chk("burst_ovf", 8'(overflow), 8'd1);
      idle(40);
      chk("burst_max_pend", 8'(max_pend), 8'd4);
      chk("burst_count", 8'(pulses.size()), 8'd5);
      pad_pulses(5);
      chk("burst_p0", 8'(pulses[0]), 8'b00100);
      chk("burst_p1", 8'(pulses[1]), 8'b00001);
      chk("burst_p2", 8'(pulses[2]), 8'b00010);
      chk("burst_p3", 8'(pulses[3]), 8'b00100);
      chk("burst_p4", 8'(pulses[4]), 8'b01000);

      // Reset in the middle of a gap with three commands queued.
      cyc(1'b1, 5'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 5'b00100, 1'b0, 8'h00, 1'b0);
      idle(1);
      cyc(1'b0, 5'b00001, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 5'b00010, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 5'b01000, 1'b0, 8'h00, 1'b0);
      chk("pre_reset_pend", 8'(pending), 8'd3);
      pulses.delete();
      cyc(1'b1, 5'b0, 1'b0, 8'h00, 1'b0);
      chk("rst_ctl", 8'(control), 8'd0);
      chk("rst_pend", 8'(pending), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      idle(30);
      chk("rst_no_pulses", 8'(pulses.size()), 8'd0);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         logic       r;
         logic [4:0] b;
         logic       v;
         logic [7:0] d;
         logic       clr;
         logic [7:0] chars [10];
         chars = '{8'h48, 8'h4D, 8'h53, 8'h52, 8'h43, 8'h68, 8'h6D, 8'h73, 8'h72, 8'h63};
         r   = ($urandom_range(0, 199) == 0);
         b   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'b0;
         v   = ($urandom_range(0, 2) == 0);
         d   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                           : chars[$urandom_range(0, 9)];
         clr = ($urandom_range(0, 15) == 0);
         cyc(r, b, v, d, clr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
